req_arbiter_8: RTL and testbench

- Arbitrates 8 requesters sharing one downstream resource; exactly one grant at a time.
- Winner selection is an 8-input priority search (bit 7 highest at reset), optionally rotated for round-robin fairness.
- Grant is held while the owner keeps requesting, up to a burst limit.
- Sits in front of any shared datapath (bus, encoder output register, memory port) and drives its select/enable.

---
 rtl/req_arbiter_8.sv | 109 ++++++++++
 tb/tb_req_arbiter_8.sv | 139 +++++++++++++
 2 files changed

// File: rtl/req_arbiter_8.sv
// rtl/req_arbiter_8.sv - 8-way request arbiter with optional round-robin rotation and hold limit
module req_arbiter_8 #(
  parameter bit          RR_EN    = 1'b1,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] grant_id,
  output logic       grant_valid,
  output logic [7:0] hold_cnt
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] id_q, id_d;
  logic [7:0] grant_q, grant_d;
  logic [7:0] hold_q, hold_d;

  logic [7:0] others;
  logic [7:0] cand;
  logic       new_grant;
  logic [3:0] pick_res;

  // Returns {found, index} of the first set bit scanning top, top-1, ... with wrap.
  function automatic logic [3:0] pick(input logic [7:0] c, input logic [2:0] top);
    logic [3:0] res;
    logic [2:0] idx;
    res = '0;
    for (int i = 7; i >= 0; i--) begin
      idx = top - 3'(i);
      if (c[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    grant_d   = grant_q;
    hold_d    = hold_q;
    cand      = '0;
    new_grant = 1'b0;
    others    = req & ~(8'd1 << id_q);

    case (state_q)
      IDLE: begin
        if (|req) begin
          cand      = req;
          new_grant = 1'b1;
        end
      end
      GRANT: begin
        if (!req[id_q] || (hold_q >= HOLD_MAX && |others)) begin
          cand      = others;
          new_grant = 1'b1;
        end else if (hold_q < HOLD_MAX) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: ;
    endcase

    pick_res = pick(cand, ptr_q);

    if (new_grant) begin
      if (pick_res[3]) begin
        state_d = GRANT;
        id_d    = pick_res[2:0];
        grant_d = 8'd1 << pick_res[2:0];
        hold_d  = 8'd1;
        if (RR_EN) ptr_d = pick_res[2:0] - 3'd1;
      end else begin
        state_d = IDLE;
        id_d    = '0;
        grant_d = '0;
        hold_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 3'd7;
      id_q    <= '0;
      grant_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      grant_q <= grant_d;
      hold_q  <= hold_d;
    end
  end

  assign grant       = grant_q;
  assign grant_id    = id_q;
  assign grant_valid = |grant_q;
  assign hold_cnt    = hold_q;

endmodule

// File: tb/tb_req_arbiter_8.sv
// tb/tb_req_arbiter_8.sv - directed self-checking bench for req_arbiter_8
module tb_req_arbiter_8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_id;
  logic       grant_valid;
  logic [7:0] hold_cnt;

  int checks   = 0;
  int failures = 0;

  req_arbiter_8 #(.RR_EN(1'b1), .MAX_HOLD(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .grant      (grant),
    .grant_id   (grant_id),
    .grant_valid(grant_valid),
    .hold_cnt   (hold_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] g, input logic [7:0] h);
    logic [2:0] id;
    id = '0;
    for (int i = 0; i < 8; i++) if (g[i]) id = 3'(i);
    check({tag, ".grant"}, grant, g);
    check({tag, ".grant_id"}, {5'd0, grant_id}, {5'd0, id});
    check({tag, ".grant_valid"}, {7'd0, grant_valid}, {7'd0, (g != 8'd0)});
    check({tag, ".hold_cnt"}, hold_cnt, h);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 8'd0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] owner;
    logic [7:0] exp_g;

    // Reset state
    rst = 1'b1;
    req = 8'h00;
    step();
    step();
    check_all("reset", 8'h00, 8'd0);

    // Reset release, two requesters: bit5 wins, ptr moves to 4
    rst = 1'b0;
    req = 8'b0010_0100;
    step();
    check_all("first_grant", 8'b0010_0000, 8'd1);
    // Owner 5 releases; with ptr=4 bit2 outranks bit7
    req = 8'b1000_0100;
    step();
    check_all("ptr_after_5", 8'b0000_0100, 8'd1);

    // Round-robin walk with all requesting, owner dropping for one cycle
    do_reset();
    req = 8'hFF;
    step();
    check_all("rr_start", 8'h80, 8'd1);
    owner = 3'd7;
    for (int n = 0; n < 8; n++) begin
      req   = 8'hFF & ~(8'd1 << owner);
      owner = owner - 3'd1;
      exp_g = 8'd1 << owner;
      step();
      check_all($sformatf("rr_seq%0d", n), exp_g, 8'd1);
    end

    // Two constant requesters: hold limit forces alternation
    do_reset();
    req = 8'b0000_0011;
    for (int c = 0; c < 9; c++) begin
      step();
      if (c < 4)      check_all($sformatf("hold_a%0d", c), 8'h02, 8'(c + 1));
      else if (c < 8) check_all($sformatf("hold_b%0d", c), 8'h01, 8'(c - 3));
      else            check_all("hold_back", 8'h02, 8'd1);
    end

    // Single requester: saturation, no gap
    do_reset();
    req = 8'b0000_1000;
    for (int c = 1; c <= 10; c++) begin
      step();
      check_all($sformatf("sat%0d", c), 8'h08, (c < 4) ? 8'(c) : 8'd4);
    end

    // Handover without idle, then idle
    do_reset();
    req = 8'b0100_0000;
    step();
    check_all("hand_6", 8'h40, 8'd1);
    req = 8'b0000_0100;
    step();
    check_all("hand_2", 8'h04, 8'd1);
    req = 8'h00;
    step();
    check_all("hand_idle", 8'h00, 8'd0);

    // Reset during an active grant
    do_reset();
    req = 8'b0010_0000;
    step();
    check_all("rst_pre", 8'h20, 8'd1);
    rst = 1'b1;
    step();
    check_all("rst_mid", 8'h00, 8'd0);
    rst = 1'b0;
    req = 8'b1010_0000;
    step();
    check_all("rst_post", 8'h80, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
